// File: rtl/maj_tt_engine.sv
// Majority-network truth-table engine: a configurable chain of 3-input MAJ gates is
// enumerated over all 2^NUM_INPUTS assignments and streamed out as packed words.
module maj_tt_engine #(
    parameter int NUM_INPUTS = 7,
    parameter int NUM_GATES  = 8,
    parameter int WORD_W     = 32,
    localparam int NNODES    = 1 + NUM_INPUTS + NUM_GATES,
    localparam int SEL_W     = $clog2(NNODES),
    localparam int CFG_W     = 3*SEL_W + 3,
    localparam int ADDR_W    = $clog2(NUM_GATES + 1),
    localparam int NWORDS    = (1 << NUM_INPUTS) / WORD_W,
    localparam int IDX_W     = (NWORDS > 1) ? $clog2(NWORDS) : 1,
    localparam int LW        = $clog2(WORD_W)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [CFG_W-1:0]      cfg_data,
    input  logic                  start,
    output logic                  busy,
    output logic                  tt_valid,
    input  logic                  tt_ready,
    output logic [WORD_W-1:0]     tt_data,
    output logic [IDX_W-1:0]      tt_index,
    output logic                  done,
    output logic [NUM_INPUTS:0]   ones_count,
    output logic                  cfg_err
);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_OUT, S_DONE} state_t;

    state_t                  state_q;
    logic [CFG_W-1:0]        gcfg_q [NUM_GATES];
    logic [SEL_W:0]          ocfg_q;
    logic [NUM_INPUTS-1:0]   cnt_q;
    logic [NUM_INPUTS:0]     ones_q;
    logic [NUM_INPUTS:0]     ones_count_q;
    logic [WORD_W-1:0]       word_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    busy_q, valid_q, done_q, cfg_err_q;

    logic [NNODES-1:0]       nodes;
    logic                    op_a, op_b, op_c, f_bit;
    logic                    wr_en, wr_err;

    // Selects at or beyond the limit (forward/self gate refs, out of range) read as 0.
    function automatic logic pick(input logic [NNODES-1:0] n, input logic [SEL_W-1:0] s,
                                  input int lim);
        return (int'(s) < lim) ? n[s] : 1'b0;
    endfunction

    // Gates resolve in index order inside one pass, so only earlier gates are visible.
    always_comb begin
        nodes = '0;
        op_a  = 1'b0;
        op_b  = 1'b0;
        op_c  = 1'b0;
        nodes[NUM_INPUTS:1] = cnt_q;
        for (int g = 0; g < NUM_GATES; g++) begin
            op_a = pick(nodes, gcfg_q[g][SEL_W-1:0],         NUM_INPUTS+1+g) ^ gcfg_q[g][3*SEL_W];
            op_b = pick(nodes, gcfg_q[g][2*SEL_W-1:SEL_W],   NUM_INPUTS+1+g) ^ gcfg_q[g][3*SEL_W+1];
            op_c = pick(nodes, gcfg_q[g][3*SEL_W-1:2*SEL_W], NUM_INPUTS+1+g) ^ gcfg_q[g][3*SEL_W+2];
            nodes[NUM_INPUTS+1+g] = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);
        end
        f_bit = pick(nodes, ocfg_q[SEL_W-1:0], NNODES) ^ ocfg_q[SEL_W];
    end

    assign wr_en = cfg_we && !busy_q;

    always_comb begin
        wr_err = 1'b0;
        if (wr_en) begin
            if (int'(cfg_addr) == NUM_GATES) begin
                wr_err = !(int'(cfg_data[SEL_W-1:0]) < NNODES);
            end else begin
                for (int g = 0; g < NUM_GATES; g++) begin
                    if (int'(cfg_addr) == g) begin
                        for (int k = 0; k < 3; k++) begin
                            if (int'(cfg_data[k*SEL_W +: SEL_W]) >= NUM_INPUTS+1+g) wr_err = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            for (int g = 0; g < NUM_GATES; g++) gcfg_q[g] <= '0;
            ocfg_q       <= '0;
            cnt_q        <= '0;
            ones_q       <= '0;
            ones_count_q <= '0;
            word_q       <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            if (wr_en) begin
                if (int'(cfg_addr) == NUM_GATES) ocfg_q <= cfg_data[SEL_W:0];
                for (int g = 0; g < NUM_GATES; g++) begin
                    if (int'(cfg_addr) == g) gcfg_q[g] <= cfg_data;
                end
            end
            // A bad write coinciding with start still reports, so set wins over clear.
            if (wr_err) cfg_err_q <= 1'b1;
            else if (state_q == S_IDLE && start) cfg_err_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_EVAL;
                        cnt_q   <= '0;
                        ones_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_EVAL: begin
                    word_q[cnt_q[LW-1:0]] <= f_bit;
                    ones_q <= ones_q + {{NUM_INPUTS{1'b0}}, f_bit};
                    cnt_q  <= cnt_q + NUM_INPUTS'(1);
                    if (&cnt_q[LW-1:0]) begin
                        state_q <= S_OUT;
                        valid_q <= 1'b1;
                        idx_q   <= IDX_W'(cnt_q >> LW);
                    end
                end
                S_OUT: begin
                    if (tt_ready) begin
                        valid_q <= 1'b0;
                        if (idx_q == IDX_W'(NWORDS-1)) begin
                            state_q      <= S_DONE;
                            done_q       <= 1'b1;
                            busy_q       <= 1'b0;
                            ones_count_q <= ones_q;
                        end else begin
                            state_q <= S_EVAL;
                        end
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign tt_valid   = valid_q;
    assign tt_data    = word_q;
    assign tt_index   = idx_q;
    assign done       = done_q;
    assign ones_count = ones_count_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_maj_tt_engine.sv
// Directed bench for maj_tt_engine: expected words are queued from a behavioural
// model at start and compared as each word is handshaken out.
module tb_maj_tt_engine;
    localparam int NI = 7, NG = 8, WW = 32, SW = 4, CW = 15, AW = 4, NW = 4, IW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [CW-1:0] cfg_data = '0;
    logic          start = 1'b0;
    logic          busy, tt_valid, done, cfg_err;
    logic          tt_ready = 1'b1;
    logic [WW-1:0] tt_data;
    logic [IW-1:0] tt_index;
    logic [NI:0]   ones_count;

    typedef struct {logic [IW-1:0] idx; logic [WW-1:0] data;} exp_t;
    exp_t exp_q[$];
    int total = 0, bad = 0;

    maj_tt_engine #(.NUM_INPUTS(NI), .NUM_GATES(NG), .WORD_W(WW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .busy(busy), .tt_valid(tt_valid), .tt_ready(tt_ready),
        .tt_data(tt_data), .tt_index(tt_index), .done(done), .ones_count(ones_count),
        .cfg_err(cfg_err));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference functions written directly in terms of the inputs.
    function automatic bit model(input int mode, input int i);
        bit x0, x1, x2, x3, x6, m;
        x0 = i[0]; x1 = i[1]; x2 = i[2]; x3 = i[3]; x6 = i[6];
        m = (x0 & x1) | (x0 & x2) | (x1 & x2);
        case (mode)
            1:       return m;
            2:       return !m;
            3:       return x6;
            4:       return m | x3;
            5:       return x0 & x1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [CW-1:0] gate(input int sa, input int sb, input int sc,
                                           input bit ia, input bit ib, input bit ic);
        logic [SW-1:0] a, b, c;
        a = SW'(sa); b = SW'(sb); c = SW'(sc);
        return {ic, ib, ia, c, b, a};
    endfunction

    task automatic cfg_write(input int addr, input logic [CW-1:0] data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_data = data;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_valid"}, tt_valid, 0);
        chk({tag, "_data"},  tt_data, 0);
        chk({tag, "_index"}, tt_index, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_ones"},  ones_count, 0);
        chk({tag, "_err"},   cfg_err, 0);
    endtask

    // One enumeration run; lat is the number of edges from the start edge to done.
    task automatic do_run(input int mode, input int stall_n, input bit disturb, output int lat);
        int ones_exp, n, stall_left;
        bit stalled;
        logic [WW-1:0] snap_d;
        logic [IW-1:0] snap_i;
        exp_t e;
        exp_q.delete();
        ones_exp = 0;
        for (int w = 0; w < NW; w++) begin
            e.idx = IW'(w);
            for (int j = 0; j < WW; j++) begin
                e.data[j] = model(mode, w*WW + j);
                ones_exp += int'(e.data[j]);
            end
            exp_q.push_back(e);
        end
        stalled = 0; stall_left = 0; lat = -1; snap_d = '0; snap_i = '0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (n = 0; n < 400; n++) begin
            @(negedge clk);
            if (n == 0) chk("busy_rise", busy, 1);
            if (disturb && n == 5) begin
                cfg_we = 1'b1; cfg_addr = AW'(NG); cfg_data = CW'({1'b1, 4'd0});
            end
            if (disturb && n == 6) cfg_we = 1'b0;
            if (disturb && n == 10) start = 1'b1;
            if (disturb && n == 11) start = 1'b0;
            if (!tt_ready) begin
                chk("stall_valid", tt_valid, 1);
                chk("stall_data", tt_data, snap_d);
                chk("stall_index", tt_index, snap_i);
                stall_left--;
                if (stall_left == 0) tt_ready = 1'b1;
            end else if (tt_valid && stall_n > 0 && !stalled && tt_index == IW'(1)) begin
                stalled = 1; tt_ready = 1'b0; stall_left = stall_n;
                snap_d = tt_data; snap_i = tt_index;
            end
            if (tt_valid && tt_ready) begin
                if (exp_q.size() == 0) chk("extra_word", tt_valid, 0);
                else begin
                    e = exp_q.pop_front();
                    chk($sformatf("m%0d_data_w%0d", mode, e.idx), tt_data, e.data);
                    chk($sformatf("m%0d_index", mode), tt_index, e.idx);
                end
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        tt_ready = 1'b1;
        if (lat < 0) chk("done_seen", done, 1);
        else begin
            chk("busy_fall", busy, 0);
            chk($sformatf("m%0d_ones", mode), ones_count, ones_exp);
            chk("words_left", exp_q.size(), 0);
            @(negedge clk);
            chk("done_pulse", done, 0);
        end
    endtask

    initial begin
        int lat;
        #1 chk_reset_outs("por");
        #20 rst_n = 1'b1;

        // Fresh reset: f == 0; done lands in cycle 4*33+1 counting from the cycle after start.
        do_run(0, 0, 0, lat);
        chk("lat_nostall", lat + 1, 133);
        chk("err_clean", cfg_err, 0);

        cfg_write(0, gate(1, 2, 3, 0, 0, 0));
        cfg_write(NG, CW'({1'b0, 4'd8}));
        do_run(1, 0, 0, lat);
        cfg_write(NG, CW'({1'b1, 4'd8}));
        do_run(2, 0, 0, lat);
        cfg_write(NG, CW'({1'b0, 4'd7}));
        do_run(3, 0, 0, lat);

        // gate1 = MAJ(gate0, x3, ~0) = gate0 | x3
        cfg_write(1, gate(8, 4, 0, 0, 0, 1));
        cfg_write(NG, CW'({1'b0, 4'd9}));
        do_run(4, 0, 0, lat);
        do_run(4, 5, 0, lat);
        chk("lat_stall", lat + 1, 138);

        // gate2 self-reference: that operand reads 0, leaving MAJ(0, x0, x1)
        cfg_write(2, gate(10, 1, 2, 0, 0, 0));
        chk("err_set", cfg_err, 1);
        cfg_write(NG, CW'({1'b0, 4'd10}));
        chk("err_sticky", cfg_err, 1);
        do_run(5, 0, 0, lat);
        chk("err_cleared", cfg_err, 0);

        cfg_write(NG, CW'({1'b0, 4'd8}));
        do_run(1, 0, 1, lat);
        chk("lat_disturb", lat + 1, 133);
        repeat (3) @(negedge clk);
        chk("no_restart", busy, 0);
        do_run(1, 0, 0, lat);

        // Abort mid-run while word 2 is presented.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (tt_valid && tt_index == IW'(2)) break;
            @(negedge clk);
        end
        chk("word2_seen", tt_valid, 1);
        rst_n = 1'b0;
        #1 chk_reset_outs("abort");
        @(negedge clk); rst_n = 1'b1;
        do_run(0, 0, 0, lat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/maj_tt_engine.md
# maj_tt_engine

Programmable majority-network truth-table engine. It holds a small netlist of 3-input majority gates with per-operand inversion, loaded through a config port. On a start pulse it enumerates all 2^NUM_INPUTS input assignments, one per cycle, and streams the function's truth table out as packed words over a valid/ready handshake. It is the parametrised, sequential successor to our fixed 7-input majority-chain functions, used for on-chip classification and checking of candidate MAJ networks.

## Interface
- NUM_INPUTS, 7: primary inputs x0..x(N-1). Legal range 5..10.
- NUM_GATES, 8: majority gates in the netlist, indexed 0..NUM_GATES-1.
- WORD_W, 32: truth-table output word width. Power of two, ≤ 2^NUM_INPUTS.
- Derived: SEL_W = clog2(1+NUM_INPUTS+NUM_GATES); NWORDS = 2^NUM_INPUTS / WORD_W.

Ports (reset is asynchronous, active-low; one clock):
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  clog2(NUM_GATES+1)  gate index; address NUM_GATES selects the output register.
- cfg_data  in  3*SEL_W+3  gate: {inv_c,inv_b,inv_a,sel_c,sel_b,sel_a}; output register: {inv,sel} in the low SEL_W+1 bits.
- start  in  1  begin enumeration (IDLE only).
- busy  out  1  high from the cycle after an accepted start through the last handshake.
- tt_valid  out  1  tt_data/tt_index valid.
- tt_ready  in  1  consumer accepts the word.
- tt_data  out  WORD_W  truth-table word; bit j = f(assignment tt_index*WORD_W+j).
- tt_index  out  clog2(NWORDS) (min 1)  word number.
- done  out  1  one-cycle pulse after the final word is accepted.
- ones_count  out  NUM_INPUTS+1  onset size of f, valid from done until the next start.
- cfg_err  out  1  sticky: an illegal select was written.

## Operation
- Operand select space: 0 = constant 0; 1..NUM_INPUTS = x(s-1); NUM_INPUTS+1+g = output of gate g.
- Gate g = MAJ(a^inv_a, b^inv_b, c^inv_c). A gate select may reference only gates < g. The output register may reference any gate or input.
- Illegal select: a gate index ≥ own index, or a value beyond the range. It is stored as written and evaluates as constant 0. The write sets cfg_err.
- Assignment index i: x_k = bit k of i, so x0 is the LSB.
- cfg_we is ignored while busy is high. It is accepted in IDLE and takes effect for the next start.
- FSM:
  - IDLE: start → EVAL, counter=0, ones=0, cfg_err cleared.
  - EVAL: each cycle, evaluate counter, write the bit to word position counter[log2 WORD_W-1:0], add it to ones, increment counter. On the cycle where the low bits are all ones → OUT.
  - OUT: tt_valid=1. On tt_ready, go to EVAL, or to DONE if this was the last word.
  - DONE: done=1 for one cycle, then → IDLE.
- start while busy is ignored.
- The counter wraps to 0 after the final assignment and is not used further.
- Evaluation is combinational across the gate chain within one cycle. There is no pipelining across gates.

## Timing
- Reset values:
  - busy=0, tt_valid=0, tt_data=0, tt_index=0, done=0, ones_count=0, cfg_err=0, FSM=IDLE.
  - All gate configs and the output register reset to 0, so f ≡ 0.
- Start is sampled at edge k. busy rises after edge k. EVAL covers the cycles after edges k..k+WORD_W-1. tt_valid is high after edge k+WORD_W.
- With tt_ready held high:
  - tt_valid is high for exactly 1 cycle per word; words are spaced WORD_W+1 cycles apart.
  - done is high in the cycle after the final handshake, and busy falls with it.
  - Default parameters: done 4*33+1 cycles after the start edge.
- Backpressure: while tt_valid && !tt_ready, tt_data and tt_index hold and no evaluation occurs.
- tt_valid never drops without a handshake, except on reset.
- ones_count updates when entering DONE. It does not change otherwise.
- Reset mid-run aborts immediately. All outputs take their reset values, and configuration is lost.
- cfg_we together with start in IDLE: the write completes and the run uses the new value.

## Test plan
- Reset then start → 4 words, all 0x00000000, indices 0..3, done pulse, ones_count=0, cfg_err=0.
- Gate0 = MAJ(x0,x1,x2), output = gate0 → every word 0xE8E8E8E8, ones_count=64. The same run with output inv=1 → 0x17171717, ones_count=64.
- Output = x6 → words 0,1 = 0x00000000, words 2,3 = 0xFFFFFFFF, ones_count=64. Chained gates: gate1 = MAJ(gate0, x3, const0 inverted) = gate0|x3, output gate1 → word0 = 0xFFE8FFE8.
- tt_ready low for 5 cycles while word 1 is valid → tt_data/tt_index stable, tt_valid stays high, done delayed by exactly 5 cycles (138 cycles after start).
- Gate2 sel_a referencing gate 2 → cfg_err=1, that operand reads 0. cfg_we during busy → ignored, and a second run yields an unchanged table. start during busy → ignored.
- rst_n asserted during word 2 → outputs return to reset values immediately. Start then yields the all-zero table.
